v2f_seq_mul_sched: RTL and testbench
====================================

V2F_SEQ_MUL_SCHED -- requirements
Module: v2f_seq_mul_sched

Interface
REQ-001 The block SHALL have parameter SIGNED, default 0: 0 treats both operands as unsigned, 1 treats both as two's complement.
REQ-002 The block SHALL have parameter Y_WIDTH, default 64: the result width; the only legal values are 64 (full product) and 32 (truncated low half).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port SRST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands A and B are presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 The block SHALL have port A, input, 32 bits: multiplicand.
REQ-008 The block SHALL have port B, input, 32 bits: multiplier.
REQ-009 The block SHALL have port out_valid, output, 1 bit: Y holds a completed result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts Y.
REQ-011 The block SHALL have port Y, output, Y_WIDTH bits: the product.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 The block SHALL contain exactly one 16x16->32 unsigned multiplier, time-shared across all partial products of one operation.
REQ-014 The block SHALL implement a state machine with states IDLE, MUL and DONE, where MUL carries a step counter 0..N-1; N=4 when Y_WIDTH=64, N=3 when Y_WIDTH=32.
REQ-015 The block SHALL drive in_ready=1 only in IDLE; an input handshake occurs at a rising edge where in_valid and in_ready are both 1.
REQ-016 On an input handshake the block SHALL register the operand magnitudes, register the result sign, clear the 64-bit accumulator, and enter MUL step 0.
- Magnitudes: the operands as given when SIGNED=0.
- Magnitudes: two's-complement absolute values when SIGNED=1 (0x80000000 maps to 0x80000000).
- Result sign: A[31]^B[31] when SIGNED=1, else 0.
REQ-017 Each MUL step SHALL add one partial product to the accumulator.
- Step 0: Alo*Blo shifted by 0.
- Step 1: Ahi*Blo shifted by 16.
- Step 2: Alo*Bhi shifted by 16.
- Step 3: Ahi*Bhi shifted by 32.
- All additions are modulo 2^64.
REQ-018 After the last step the block SHALL enter DONE, with Y = accumulator[Y_WIDTH-1:0], two's-complement negated if the result sign is 1.
REQ-019 The latency SHALL be fixed: out_valid rises N rising edges after the accepting edge, independent of operand values.
REQ-020 In DONE the block SHALL hold out_valid=1 and Y constant until a rising edge with out_ready=1, then return to IDLE with out_valid=0.
REQ-021 Operations SHALL NOT overlap: in_valid is ignored in MUL and DONE, and the earliest next accept is the edge after the output handshake.
REQ-022 In DONE, out_ready low for any number of cycles SHALL NOT alter Y or the state.
REQ-023 Y SHALL equal the mathematical product of the signed or unsigned operands modulo 2^Y_WIDTH for all inputs.
REQ-024 Zero operands SHALL NOT cause early completion; latency remains N.

Reset
REQ-025 When SRST=1 at a rising edge, the block SHALL enter IDLE from any state, aborting any operation in progress, and discard that operation's result.
REQ-026 The first cycle after reset SHALL have in_ready=1, out_valid=0, busy=0, Y=0, accumulator=0 and step=0.
REQ-027 SRST SHALL take priority over simultaneous in_valid and out_ready.

Verification
REQ-028 The bench SHALL cover: SIGNED=0, Y_WIDTH=64, A=0xFFFFFFFF, B=0xFFFFFFFF -> Y=0xFFFFFFFE00000001, out_valid high exactly 4 edges after accept.
REQ-029 The bench SHALL cover: Y_WIDTH=32, A=0x00010003, B=0x00020005 -> Y=0x000B000F, out_valid 3 edges after accept.
REQ-030 The bench SHALL cover two signed cases.
- SIGNED=1, Y_WIDTH=64, A=0xFFFFFFFD, B=0x00000007 -> Y=0xFFFFFFFFFFFFFFEB.
- A=B=0x80000000 -> Y=0x4000000000000000.
REQ-031 The bench SHALL cover backpressure: out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands -> Y stable, in_ready=0, no accept; out_ready=1 -> IDLE next cycle, new operands accepted the edge after.
REQ-032 The bench SHALL cover reset mid-operation: SRST=1 for one edge at MUL step 2 -> next cycle in_ready=1, out_valid=0, Y=0; a following A=0, B=0x12345678 -> Y=0 after the full N-edge latency.
REQ-033 The bench SHALL cover random regression: at least 10k random A/B for each SIGNED and Y_WIDTH combination, compared against a reference product, with back-to-back in_valid and random out_ready.

Source files
------------

// File: rtl/v2f_seq_mul_sched_if.sv
// Handshake bundle for the sequential multiplier: an operand channel in and a product channel out.
// The multiplier uses the slave modport; its producer/consumer uses master.
interface v2f_seq_mul_sched_if #(
    parameter int Y_WIDTH = 64
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        A;
    logic [31:0]        B;
    logic               out_valid;
    logic               out_ready;
    logic [Y_WIDTH-1:0] Y;
    logic               busy;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Y, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Y, busy
    );
endinterface

// File: rtl/v2f_seq_mul_sched.sv
// Sequential 32x32 multiplier built around one shared 16x16 multiplier.
// Signed operands are reduced to magnitudes and the sign is applied once at the end.
module v2f_seq_mul_sched #(
    parameter bit SIGNED  = 1'b0,
    parameter int Y_WIDTH = 64
) (
    input  logic               CLK,
    input  logic               SRST,
    v2f_seq_mul_sched_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    // The truncated result never needs Ahi*Bhi, which only reaches bits 32 and up.
    localparam logic [1:0] LAST_STEP = (Y_WIDTH == 64) ? 2'd3 : 2'd2;

    logic [1:0]         state_q, state_d;
    logic [1:0]         step_q, step_d;
    logic [31:0]        aMag_q, aMag_d;
    logic [31:0]        bMag_q, bMag_d;
    logic               neg_q, neg_d;
    logic [63:0]        acc_q, acc_d;
    logic [Y_WIDTH-1:0] y_q, y_d;

    logic               aNeg, bNeg;
    logic [15:0]        mulA, mulB;
    logic [31:0]        mulP;
    logic [63:0]        partial;
    logic [63:0]        accSum;
    logic [63:0]        signedSum;

    assign aNeg = SIGNED && bus.A[31];
    assign bNeg = SIGNED && bus.B[31];

    // Step bit 0 picks the A half and step bit 1 picks the B half.
    assign mulA = step_q[0] ? aMag_q[31:16] : aMag_q[15:0];
    assign mulB = step_q[1] ? bMag_q[31:16] : bMag_q[15:0];
    assign mulP = 32'(mulA) * 32'(mulB);

    always_comb begin
        partial = {32'd0, mulP};
        case (step_q)
            2'd1, 2'd2: partial = {16'd0, mulP, 16'd0};
            2'd3:       partial = {mulP, 32'd0};
            default:    partial = {32'd0, mulP};
        endcase
    end

    assign accSum    = acc_q + partial;
    assign signedSum = neg_q ? (64'd0 - accSum) : accSum;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        aMag_d  = aMag_q;
        bMag_d  = bMag_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = MUL;
                    step_d  = 2'd0;
                    acc_d   = 64'd0;
                    aMag_d  = aNeg ? (32'd0 - bus.A) : bus.A;
                    bMag_d  = bNeg ? (32'd0 - bus.B) : bus.B;
                    neg_d   = aNeg ^ bNeg;
                end
            end
            MUL: begin
                acc_d = accSum;
                if (step_q == LAST_STEP) begin
                    state_d = DONE;
                    step_d  = 2'd0;
                    y_d     = signedSum[Y_WIDTH-1:0];
                end else begin
                    step_d = step_q + 2'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (SRST) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            aMag_q  <= 32'd0;
            bMag_q  <= 32'd0;
            neg_q   <= 1'b0;
            acc_q   <= 64'd0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            aMag_q  <= aMag_d;
            bMag_q  <= bMag_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.Y         = y_q;
endmodule

// File: tb/tb_v2f_seq_mul_sched.sv
// Bench for v2f_seq_mul_sched: four instances cover every SIGNED/Y_WIDTH pairing,
// checked each cycle against a transaction-level model, plus hand-computed directed cases.
module tb_v2f_seq_mul_sched;
    logic clk = 1'b0;
    logic srst;

    logic        inValid  [4];
    logic [31:0] aIn      [4];
    logic [31:0] bIn      [4];
    logic        outReady [4];
    logic        inReady  [4];
    logic        outValid [4];
    logic        busyOut  [4];
    logic [63:0] yOut     [4];

    always #5 clk = ~clk;

    // Instance g: bit 0 selects SIGNED, g >= 2 selects the truncated 32-bit result.
    for (genvar g = 0; g < 4; g++) begin : gDut
        localparam bit IS_SIGNED = (g % 2) == 1;
        localparam int WIDTH     = (g < 2) ? 64 : 32;

        v2f_seq_mul_sched_if #(.Y_WIDTH(WIDTH)) bus ();

        v2f_seq_mul_sched #(.SIGNED(IS_SIGNED), .Y_WIDTH(WIDTH)) dut (
            .CLK  (clk),
            .SRST (srst),
            .bus  (bus.slave)
        );

        assign bus.in_valid  = inValid[g];
        assign bus.A         = aIn[g];
        assign bus.B         = bIn[g];
        assign bus.out_ready = outReady[g];
        assign inReady[g]    = bus.in_ready;
        assign outValid[g]   = bus.out_valid;
        assign busyOut[g]    = bus.busy;
        assign yOut[g]       = 64'(bus.Y);
    end

    int checkCount = 0;
    int passCount  = 0;

    // Model: an operation is either absent, in flight with a countdown, or waiting to be taken.
    bit          mBusy      [4];
    bit          mDone      [4];
    bit          mPostReset [4];
    int          mLeft      [4];
    logic [63:0] mExp       [4];
    int          mAccepts   [4];

    function automatic int latencyOf(input int g);
        return (g < 2) ? 4 : 3;
    endfunction

    function automatic logic [63:0] refProduct(input int g, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        if (g % 2 == 1) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = 64'(sa * sb);
        end else begin
            p = {32'd0, a} * {32'd0, b};
        end
        if (g >= 2) begin
            p = {32'd0, p[31:0]};
        end
        return p;
    endfunction

    function automatic logic [31:0] randOperand();
        int sel;
        sel = $urandom_range(0, 15);
        case (sel)
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            5:       return 32'($urandom_range(0, 65535));
            default: return $urandom();
        endcase
    endfunction

    task automatic checkOutput(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s dut%0d: got 0x%h, expected 0x%h", name, g, act, exp);
        end
    endtask

    task automatic modelUpdate();
        for (int g = 0; g < 4; g++) begin
            if (srst) begin
                mBusy[g]      = 1'b0;
                mDone[g]      = 1'b0;
                mPostReset[g] = 1'b1;
            end else begin
                mPostReset[g] = 1'b0;
                if (!mBusy[g] && !mDone[g] && inValid[g]) begin
                    mBusy[g] = 1'b1;
                    mLeft[g] = latencyOf(g);
                    mExp[g]  = refProduct(g, aIn[g], bIn[g]);
                    mAccepts[g]++;
                end else if (mBusy[g]) begin
                    mLeft[g]--;
                    if (mLeft[g] == 0) begin
                        mBusy[g] = 1'b0;
                        mDone[g] = 1'b1;
                    end
                end else if (mDone[g] && outReady[g]) begin
                    mDone[g] = 1'b0;
                end
            end
        end
    endtask

    task automatic modelCheck();
        for (int g = 0; g < 4; g++) begin
            checkOutput("in_ready", g, 64'(inReady[g]), 64'(!mBusy[g] && !mDone[g]));
            checkOutput("out_valid", g, 64'(outValid[g]), 64'(mDone[g]));
            checkOutput("busy", g, 64'(busyOut[g]), 64'(mBusy[g] || mDone[g]));
            if (mDone[g]) begin
                checkOutput("Y", g, yOut[g], mExp[g]);
            end
            if (mPostReset[g]) begin
                checkOutput("Y after reset", g, yOut[g], 64'd0);
            end
        end
    endtask

    // Inputs set by the caller are sampled at the coming edge; outputs are checked 1 unit after it.
    task automatic stepCycle();
        modelUpdate();
        @(posedge clk);
        #1;
        modelCheck();
    endtask

    task automatic waitResult(input int g, input logic [63:0] expY, input int expLat, input string name);
        int edges;
        edges = 0;
        while (outValid[g] !== 1'b1 && edges < 20) begin
            stepCycle();
            edges++;
        end
        checkOutput({name, " latency"}, g, 64'(edges), 64'(expLat));
        checkOutput({name, " Y"}, g, yOut[g], expY);
    endtask

    task automatic applyStimulus(input int g, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] expY, input int expLat, input string name);
        checkOutput({name, " model"}, g, refProduct(g, a, b), expY);
        aIn[g]     = a;
        bIn[g]     = b;
        inValid[g] = 1'b1;
        stepCycle();
        inValid[g] = 1'b0;
        waitResult(g, expY, expLat, name);
        outReady[g] = 1'b1;
        stepCycle();
        outReady[g] = 1'b0;
    endtask

    initial begin
        int  cycles;
        bit  allDone;
        int  target;

        srst = 1'b1;
        for (int g = 0; g < 4; g++) begin
            inValid[g]    = 1'b0;
            outReady[g]   = 1'b0;
            aIn[g]        = 32'd0;
            bIn[g]        = 32'd0;
            mBusy[g]      = 1'b0;
            mDone[g]      = 1'b0;
            mPostReset[g] = 1'b0;
            mLeft[g]      = 0;
            mExp[g]       = 64'd0;
            mAccepts[g]   = 0;
        end
        stepCycle();
        stepCycle();
        srst = 1'b0;
        for (int g = 0; g < 4; g++) begin
            checkOutput("reset in_ready", g, 64'(inReady[g]), 64'd1);
            checkOutput("reset out_valid", g, 64'(outValid[g]), 64'd0);
            checkOutput("reset busy", g, 64'(busyOut[g]), 64'd0);
            checkOutput("reset Y", g, yOut[g], 64'd0);
        end

        $display("[TB] directed products");
        applyStimulus(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4, "umax64");
        applyStimulus(2, 32'h0001_0003, 32'h0002_0005, 64'h0000_0000_000B_000F, 3, "trunc32");
        applyStimulus(1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 4, "neg64");
        applyStimulus(1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 4, "minmin64");
        applyStimulus(3, 32'hFFFF_FFFD, 32'h0000_0007, 64'h0000_0000_FFFF_FFEB, 3, "neg32");
        applyStimulus(2, 32'h1234_5678, 32'h0000_0000, 64'd0, 3, "zero32");

        $display("[TB] backpressure");
        aIn[0]     = 32'd3;
        bIn[0]     = 32'd5;
        inValid[0] = 1'b1;
        stepCycle();
        inValid[0] = 1'b0;
        waitResult(0, 64'd15, 4, "bp first");
        aIn[0]     = 32'd7;
        bIn[0]     = 32'd9;
        inValid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            checkOutput("bp held Y", 0, yOut[0], 64'd15);
            checkOutput("bp held in_ready", 0, 64'(inReady[0]), 64'd0);
            checkOutput("bp held out_valid", 0, 64'(outValid[0]), 64'd1);
        end
        outReady[0] = 1'b1;
        stepCycle();
        outReady[0] = 1'b0;
        checkOutput("bp idle in_ready", 0, 64'(inReady[0]), 64'd1);
        checkOutput("bp idle out_valid", 0, 64'(outValid[0]), 64'd0);
        stepCycle();
        inValid[0] = 1'b0;
        checkOutput("bp next accepted", 0, 64'(busyOut[0]), 64'd1);
        waitResult(0, 64'd63, 4, "bp second");
        outReady[0] = 1'b1;
        stepCycle();
        outReady[0] = 1'b0;

        $display("[TB] reset mid-operation");
        aIn[0]     = 32'hDEAD_BEEF;
        bIn[0]     = 32'h0000_1234;
        inValid[0] = 1'b1;
        stepCycle();
        inValid[0] = 1'b0;
        stepCycle();
        stepCycle();
        srst       = 1'b1;
        inValid[2] = 1'b1;
        aIn[2]     = 32'd11;
        bIn[2]     = 32'd13;
        stepCycle();
        srst       = 1'b0;
        inValid[2] = 1'b0;
        checkOutput("abort in_ready", 0, 64'(inReady[0]), 64'd1);
        checkOutput("abort out_valid", 0, 64'(outValid[0]), 64'd0);
        checkOutput("abort Y", 0, yOut[0], 64'd0);
        checkOutput("reset beats in_valid", 2, 64'(busyOut[2]), 64'd0);
        applyStimulus(0, 32'd0, 32'h1234_5678, 64'd0, 4, "zero64");

        $display("[TB] random regression");
        target = 10000;
        for (int g = 0; g < 4; g++) begin
            mAccepts[g] = 0;
        end
        cycles  = 0;
        allDone = 1'b0;
        while (cycles < 90000) begin
            allDone = 1'b1;
            for (int g = 0; g < 4; g++) begin
                if (mAccepts[g] < target || mBusy[g] || mDone[g]) begin
                    allDone = 1'b0;
                end
            end
            if (allDone) begin
                break;
            end
            for (int g = 0; g < 4; g++) begin
                inValid[g]  = (mAccepts[g] < target);
                aIn[g]      = randOperand();
                bIn[g]      = randOperand();
                outReady[g] = ($urandom_range(0, 7) != 0);
            end
            stepCycle();
            cycles++;
        end
        checkOutput("random regression completed", 0, 64'(allDone), 64'd1);
        for (int g = 0; g < 4; g++) begin
            inValid[g]  = 1'b0;
            outReady[g] = 1'b0;
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
